// File: rtl/spi_regfile_peripheral.sv
// SPI target exposing NUM_REGS x DATA_W control registers, with writes and read-back in any SPI mode.
// Every SPI pin is oversampled in the clk domain; spi_sclk never clocks a flop.
module spi_regfile_peripheral #(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       spi_sclk,
  input  logic                       spi_cs_n,
  input  logic                       spi_mosi,
  output logic                       spi_miso,
  output logic                       spi_miso_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);
  localparam int CNT_W = $clog2(ADDR_W + DATA_W + 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t state, state_nx;

  logic [2:0] sclk_s, cs_s;
  logic [1:0] mosi_s, settle;
  logic       armed;

  // CS syncs reset high so no false edge; 'armed' makes a CS already low at reset wait for a fresh fall
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sclk_s <= '0;
      cs_s   <= '1;
      mosi_s <= '0;
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[1:0], spi_sclk};
      cs_s   <= {cs_s[1:0], spi_cs_n};
      mosi_s <= {mosi_s[0], spi_mosi};
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && cs_s[2]) armed <= 1'b1;
    end

  logic sclk_rise, sclk_fall, lead, trail, smp, shf, cs_rise, cs_fall, mosi_b;
  assign sclk_rise   = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall   = ~sclk_s[1] & sclk_s[2];
  assign lead        = CPOL ? sclk_fall : sclk_rise;
  assign trail       = CPOL ? sclk_rise : sclk_fall;
  assign smp         = CPHA ? trail : lead;
  assign shf         = CPHA ? lead : trail;
  assign cs_rise     = cs_s[1] & ~cs_s[2];
  assign cs_fall     = ~cs_s[1] & cs_s[2] & armed;
  assign mosi_b      = mosi_s[1];
  assign spi_miso_oe = ~cs_s[1];

  logic [CNT_W-1:0]                cnt;
  logic [ADDR_W:0]                 cmd_sh, cmd_nx;
  logic [DATA_W-1:0]               data_sh, data_nx, tx_sh, rd_data;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic                            rw, in_range, last_cmd, last_data, abort;

  assign cmd_nx    = {cmd_sh[ADDR_W-1:0], mosi_b};
  assign data_nx   = DATA_W'({data_sh, mosi_b});
  assign rw        = cmd_sh[ADDR_W];
  assign in_range  = {1'b0, cmd_sh[ADDR_W-1:0]} < (ADDR_W+1)'(NUM_REGS);
  assign last_cmd  = smp && (cnt == CNT_W'(ADDR_W));
  assign last_data = smp && (cnt == CNT_W'(DATA_W - 1));
  assign regs_out  = regs;

  // Read mux keyed on the address as it completes; unmapped addresses read as zero
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (cmd_nx[ADDR_W-1:0] == ADDR_W'(k)) rd_data = regs[k];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    abort    = 1'b0;
    case (state)
      IDLE: if (cs_fall) state_nx = CMD;
      CMD:  if (cs_rise) begin
              state_nx = IDLE;
              abort    = 1'b1;
            end else if (last_cmd) state_nx = DATA;
      DATA: if (cs_rise) begin
              state_nx = IDLE;
              abort    = 1'b1;
            end else if (last_data) state_nx = DONE;
      DONE: if (cs_rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      cmd_sh    <= '0;
      data_sh   <= '0;
      tx_sh     <= '0;
      regs      <= '0;
      spi_miso  <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= abort;
      if (abort) spi_miso <= 1'b0;
      case (state)
        IDLE: if (cs_fall) begin
                cnt     <= '0;
                cmd_sh  <= '0;
                data_sh <= '0;
              end
        CMD:  if (!cs_rise && smp) begin
                cmd_sh <= cmd_nx;
                cnt    <= last_cmd ? '0 : cnt + 1'b1;
                if (last_cmd) tx_sh <= rd_data;
              end
        // A CS rise on the final sample beats the commit
        DATA: if (!cs_rise) begin
                if (smp) begin
                  data_sh <= data_nx;
                  cnt     <= cnt + 1'b1;
                  if (last_data) begin
                    spi_miso <= 1'b0;
                    if (rw && in_range) begin
                      for (int k = 0; k < NUM_REGS; k++)
                        if (cmd_sh[ADDR_W-1:0] == ADDR_W'(k)) regs[k] <= data_nx;
                      wr_stb  <= 1'b1;
                      wr_addr <= cmd_sh[ADDR_W-1:0];
                    end
                  end
                end else if (shf && !rw) begin
                  spi_miso <= tx_sh[DATA_W-1];
                  tx_sh    <= tx_sh << 1;
                end
              end
        default: ;
      endcase
    end
endmodule

// File: doc/spi_regfile_peripheral.md
# spi_regfile_peripheral

Parametrised SPI target that exposes a bank of `NUM_REGS` × `DATA_W` control registers to an external SPI controller. It supports writes and read-back over MISO in any of the four SPI modes. It sits between the chip's SPI pins and the output-enable/PWM control logic, replacing the fixed five-register, write-only peripheral. All SPI inputs are synchronised into the `clk` domain; no logic runs on `spi_sclk`.

## Interface
- `NUM_REGS`, 5: number of registers, 1..2^`ADDR_W`.
- `DATA_W`, 8: register and data-phase width, 1..32.
- `ADDR_W`, 7: address-phase width.
- `CPOL`, 0: SCLK idle level.
- `CPHA`, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- Reset `rst_n`, asynchronous, active-low; clock `clk`.
- `clk` in 1: system clock.
- `rst_n` in 1: async active-low reset.
- `spi_sclk` in 1: SPI clock, asynchronous to `clk`.
- `spi_cs_n` in 1: chip select, active low.
- `spi_mosi` in 1: controller-to-target data.
- `spi_miso` out 1: target-to-controller data.
- `spi_miso_oe` out 1: MISO output enable; high while the synchronised CS is low.
- `regs_out` out `NUM_REGS*DATA_W`: flat register bank, reg k at `[k*DATA_W +: DATA_W]`.
- `wr_stb` out 1: one-cycle pulse on every committed write.
- `wr_addr` out `ADDR_W`: address of the last committed write; held between writes.
- `frame_err` out 1: one-cycle pulse when a frame is aborted.

## Operation
- **Synchronisers:** `spi_sclk`, `spi_cs_n` and `spi_mosi` each pass through 2 flops. Edges are detected from the 2nd and 3rd flop stages, so MOSI is sampled aligned with the SCLK edge.
- **Edge naming:** the leading edge is rising when `CPOL`=0 and falling when `CPOL`=1.
  - Sample edge = leading if `CPHA`=0, trailing if `CPHA`=1.
  - Shift edge = the other one.
- **Frame format**, MSB first: 1 R/W bit (1 = write, 0 = read), then `ADDR_W` address bits, then `DATA_W` data bits. Frame length F = 1+`ADDR_W`+`DATA_W`.
- **FSM states:** IDLE, CMD, DATA, DONE.
  - IDLE → CMD on CS falling edge. The bit counter is cleared and the shifter cleared.
  - CMD samples the R/W bit and address. CMD → DATA when the last address bit is sampled.
  - **Read:** on entry to DATA, load `regs_out[addr]` into the TX shifter. Load 0 if addr ≥ `NUM_REGS`. The MSB is driven on the first shift edge after the last address bit; the next bit follows on each later shift edge.
  - DATA → DONE when `DATA_W` data bits have been sampled.
  - **Write commit:** if R/W=1 and addr < `NUM_REGS`, write the data in the cycle DONE is entered. Assert `wr_stb` and update `wr_addr` in that same cycle. If addr ≥ `NUM_REGS`, drop the write: no strobe, no register change.
  - DONE ignores further SCLK edges and MOSI. DONE → IDLE on CS rising edge.
  - **Abort:** a CS rising edge in CMD or DATA returns to IDLE, pulses `frame_err` for one cycle and commits nothing.
- **Read/write ordering:** a read of the register written in the immediately preceding frame returns the new value.
- **MISO:** `spi_miso` is 0 outside the DATA phase of a read, including the whole of a write frame.
- **Reset mid-frame:** all state returns to reset values immediately. The first frame after `rst_n` rises must begin with a CS falling edge seen after reset; a CS that is already low is ignored until it rises and falls again.

## Timing
- **Reset values:**
  - `regs_out` = 0, `wr_addr` = 0.
  - `wr_stb`, `frame_err`, `spi_miso`, `spi_miso_oe` = 0.
  - Synchronisers = 0 for SCLK/MOSI and 1 for CS. CS is deasserted at reset, so no false edge is generated.
  - FSM = IDLE.
- **Edge latency:** an SCLK/CS edge acts 3 `clk` rising edges after it occurs at the pin.
- **Write latency:** `regs_out` and `wr_stb` update on the clk edge after the last data bit is sampled. That is ≤4 clk after the final sample-edge SCLK transition.
- **MISO latency:** `spi_miso` changes ≤4 clk after a shift-edge SCLK transition.
- **Clock ratio:** the SCLK high and low times must each be ≥ 4 `clk` periods. The CS setup before the first SCLK edge, and the CS hold after the last SCLK edge, must each be ≥ 4 `clk` periods.
- **Back-to-back frames:** a CS high time of ≥ 4 `clk` between frames is sufficient; no extra idle is required.
- **Simultaneous events:** if a CS rising edge coincides with the final data sample, the abort wins. The frame is not committed and `frame_err` pulses.

## Test plan
- **Mode 0, defaults, write:** write frame with R/W=1, addr 4, data 0x80 → `regs_out[39:32]`=0x80, one `wr_stb` pulse, `wr_addr`=4, other registers 0.
- **Mode 3, write then read:** write 0xA5 to addr 1, then read addr 1 → MISO bits 1,0,1,0,0,1,0,1 on successive sample edges; `wr_stb` does not pulse during the read frame.
- **Out-of-range addresses:** write 0xFF to addr 9, then read addr 9 → no `wr_stb`, `regs_out` unchanged, read returns 0x00.
- **Aborted frame:** CS rises after 12 of 16 bits of a write to addr 0 → `frame_err` pulses once, `regs_out` unchanged. An immediately following full frame commits normally.
- **Over-long frame:** 20 SCLK pulses on a write to addr 2 with data 0x3C → 0x3C is committed once and the extra bits are ignored.
- **Reset mid-frame:** assert `rst_n` low in the middle of a read → all outputs are 0. The next full write, with `NUM_REGS`=16 and `DATA_W`=16 in a second build, commits 0xBEEF to addr 15.
